// File: rtl/park_pipe.sv
// Pipelined forward/inverse Park transform with valid/ready flow control,
// round-half-up, saturation, sticky overflow flag and per-sample tag.
module park_pipe #(
    parameter int D_WIDTH = 18,
    parameter int Q_BITS  = 15,
    parameter int TAG_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic [TAG_W-1:0]          in_tag,
    input  logic signed [D_WIDTH-1:0] in_x,
    input  logic signed [D_WIDTH-1:0] in_y,
    input  logic signed [D_WIDTH-1:0] sin_t,
    input  logic signed [D_WIDTH-1:0] cos_t,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [D_WIDTH-1:0] out_x,
    output logic signed [D_WIDTH-1:0] out_y,
    output logic [TAG_W-1:0]          out_tag,
    output logic [1:0]                out_sat,
    output logic                      sat_sticky,
    input  logic                      clr
);

    localparam int PW = 2 * D_WIDTH;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] RND     = SW'(1) <<< (Q_BITS - 1);
    localparam logic signed [SW-1:0] SAT_MAX = (SW'(1) <<< (D_WIDTH - 1)) - SW'(1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic adv;

    logic                      v1, m1;
    logic [TAG_W-1:0]          t1;
    logic signed [D_WIDTH-1:0] x1, y1, s1, c1;

    logic                      v2, m2;
    logic [TAG_W-1:0]          t2;
    logic signed [PW-1:0]      xc, ys, xs, yc;

    logic signed [SW-1:0]      sum_x, sum_y;
    logic signed [D_WIDTH-1:0] rx, ry;
    logic [1:0]                sat_nxt;

    // Single global enable: the whole pipe, bubbles included, freezes on a stall.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1 <= 1'b0;
            m1 <= 1'b0;
            t1 <= '0;
            x1 <= '0;
            y1 <= '0;
            s1 <= '0;
            c1 <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                m1 <= mode;
                t1 <= in_tag;
                x1 <= in_x;
                y1 <= in_y;
                s1 <= sin_t;
                c1 <= cos_t;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2 <= 1'b0;
            m2 <= 1'b0;
            t2 <= '0;
            xc <= '0;
            ys <= '0;
            xs <= '0;
            yc <= '0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                m2 <= m1;
                t2 <= t1;
                xc <= PW'(x1) * PW'(c1);
                ys <= PW'(y1) * PW'(s1);
                xs <= PW'(x1) * PW'(s1);
                yc <= PW'(y1) * PW'(c1);
            end
        end
    end

    // Returns {clamped, value}: round half up, then clamp to the output range.
    function automatic logic [D_WIDTH:0] round_sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] r;
        r = (s + RND) >>> Q_BITS;
        if (r > SAT_MAX)
            return {1'b1, SAT_MAX[D_WIDTH-1:0]};
        else if (r < SAT_MIN)
            return {1'b1, SAT_MIN[D_WIDTH-1:0]};
        return {1'b0, r[D_WIDTH-1:0]};
    endfunction

    always_comb begin
        sum_x = '0;
        sum_y = '0;
        if (m2) begin
            sum_x = SW'(xc) - SW'(ys);
            sum_y = SW'(xs) + SW'(yc);
        end else begin
            sum_x = SW'(xc) + SW'(ys);
            sum_y = SW'(yc) - SW'(xs);
        end
        {sat_nxt[0], rx} = round_sat(sum_x);
        {sat_nxt[1], ry} = round_sat(sum_y);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_tag   <= '0;
            out_sat   <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                out_x   <= rx;
                out_y   <= ry;
                out_tag <= t2;
                out_sat <= sat_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sat_sticky <= 1'b0;
        else if (clr)
            sat_sticky <= 1'b0;
        else if (adv && v2 && |sat_nxt)
            sat_sticky <= 1'b1;
    end

endmodule

// File: tb/tb_park_pipe.sv
// Directed self-checking bench for park_pipe (D_WIDTH=18, Q_BITS=15, TAG_W=2).
module tb_park_pipe;

    localparam int DW = 18;
    localparam int QB = 15;
    localparam int TW = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 mode = 1'b0;
    logic [TW-1:0]        in_tag = '0;
    logic signed [DW-1:0] in_x = '0, in_y = '0, sin_t = '0, cos_t = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [DW-1:0] out_x, out_y;
    logic [TW-1:0]        out_tag;
    logic [1:0]           out_sat;
    logic                 sat_sticky;
    logic                 clr = 1'b0;

    park_pipe #(.D_WIDTH(DW), .Q_BITS(QB), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_tag(in_tag), .in_x(in_x), .in_y(in_y),
        .sin_t(sin_t), .cos_t(cos_t), .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_tag(out_tag), .out_sat(out_sat),
        .sat_sticky(sat_sticky), .clr(clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input longint obs, input longint exp,
                         input longint tol = 0);
        longint d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d <= tol) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    endtask

    typedef struct {
        logic [TW-1:0] tag;
        longint        x;
        longint        y;
        logic [1:0]    sat;
    } res_t;

    res_t rq[$];
    res_t mon_r;

    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            mon_r.tag = out_tag;
            mon_r.x   = out_x;
            mon_r.y   = out_y;
            mon_r.sat = out_sat;
            rq.push_back(mon_r);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [TW-1:0] t, input int x, input int y,
                         input int s, input int c);
        mode   = m;
        in_tag = t;
        in_x   = DW'(x);
        in_y   = DW'(y);
        sin_t  = DW'(s);
        cos_t  = DW'(c);
        in_valid = 1'b1;
    endtask

    // Present one sample, wait until it is accepted, return one tick after the accepting edge.
    task automatic send(input logic m, input logic [TW-1:0] t, input int x, input int y,
                        input int s, input int c);
        int b;
        drive(m, t, x, y, s, c);
        b = 0;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        if (b == 50) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    // Result is on out_* one tick after the third edge.
    task automatic run1(input logic m, input logic [TW-1:0] t, input int x, input int y,
                        input int s, input int c);
        send(m, t, x, y, s, c);
        tick();
        tick();
    endtask

    task automatic wait_q(input int n);
        int b;
        b = 0;
        while (rq.size() < n && b < 40) begin
            tick();
            b++;
        end
        tick();
        tick();
        check("queue_count", rq.size(), n);
    endtask

    int va[64], vb[64], sn[64], cs[64], dd[64], dq[64];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic fire;
        longint snap_x;
        real th;

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_sticky", sat_sticky, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        check("rst_in_ready", in_ready, 1);

        // Unit cosine, with exact latency check
        send(1'b0, 2'b01, 16384, 0, 0, 32767);
        tick();
        check("lat_early_valid", out_valid, 0);
        tick();
        check("lat_valid", out_valid, 1);
        check("fwd_cos_x", out_x, 16384);
        check("fwd_cos_y", out_y, 0);
        check("fwd_cos_sat", out_sat, 0);
        check("fwd_cos_tag", out_tag, 1);

        run1(1'b0, 2'b10, 16384, 0, 32767, 0);
        check("fwd_sin_x", out_x, 0);
        check("fwd_sin_y", out_y, -16383);
        check("fwd_sin_tag", out_tag, 2);

        // Round half up: +0.5 -> 1, -0.5 -> 0
        run1(1'b0, 2'b00, 1, 0, 0, 16384);
        check("round_pos_half", out_x, 1);
        run1(1'b0, 2'b00, -1, 0, 0, 16384);
        check("round_neg_half", out_x, 0);

        run1(1'b0, 2'b11, 131071, 131071, 32767, 32767);
        check("sat_pos_x", out_x, 131071);
        check("sat_pos_y", out_y, 0);
        check("sat_pos_flags", out_sat, 1);
        check("sat_pos_sticky", sat_sticky, 1);
        tick(); tick(); tick();
        check("sticky_hold", sat_sticky, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sticky_clr", sat_sticky, 0);

        run1(1'b1, 2'b00, -131072, -131072, 32767, 32767);
        check("sat_inv_x", out_x, 0);
        check("sat_inv_y", out_y, -131072);
        check("sat_inv_flags", out_sat, 2);
        check("sat_inv_sticky", sat_sticky, 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;

        // clr on the same edge that loads a saturated result
        send(1'b0, 2'b00, -131072, -131072, 32767, 32767);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_win_x", out_x, -131072);
        check("clr_win_flags", out_sat, 1);
        check("clr_win_sticky", sat_sticky, 0);
        tick();
        check("clr_win_after", sat_sticky, 0);

        // Stall: out_ready low for 10 cycles with in_valid high
        tick(); tick(); tick();
        rq.delete();
        out_ready = 1'b0;
        acc = 0;
        snap_x = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, TW'(acc + 1), 100 * (acc + 1), 0, 0, 32767);
            fire = in_ready;
            tick();
            if (fire) acc++;
            if (c == 4) snap_x = out_x;
        end
        check("stall_accepted", acc, 3);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_x", out_x, 100);
        check("stall_stable_x", out_x, snap_x);
        check("stall_out_tag", out_tag, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_q(3);
        for (int i = 0; i < 3 && i < rq.size(); i++) begin
            check("stall_rel_x", rq[i].x, 100 * (i + 1));
            check("stall_rel_tag", rq[i].tag, i + 1);
        end

        // Round trip: forward batch, then inverse interleaved with a forward repeat
        for (int i = 0; i < 64; i++) begin
            th    = $itor($urandom_range(0, 6283)) / 1000.0;
            cs[i] = $rtoi(32767.0 * $cos(th));
            sn[i] = $rtoi(32767.0 * $sin(th));
            va[i] = int'($urandom_range(0, 16000)) - 8000;
            vb[i] = int'($urandom_range(0, 16000)) - 8000;
        end
        rq.delete();
        for (int i = 0; i < 64; i++) begin
            drive(1'b0, TW'(i), va[i], vb[i], sn[i], cs[i]);
            tick();
        end
        in_valid = 1'b0;
        wait_q(64);
        for (int i = 0; i < 64 && i < rq.size(); i++) begin
            dd[i] = int'(rq[i].x);
            dq[i] = int'(rq[i].y);
        end
        rq.delete();
        for (int i = 0; i < 64; i++) begin
            drive(1'b1, TW'(2 + (i % 2)), dd[i], dq[i], sn[i], cs[i]);
            tick();
            drive(1'b0, TW'(i % 2), va[i], vb[i], sn[i], cs[i]);
            tick();
        end
        in_valid = 1'b0;
        wait_q(128);
        for (int i = 0; i < 64 && 2 * i + 1 < rq.size(); i++) begin
            check("rt_inv_x", rq[2*i].x, va[i], 2);
            check("rt_inv_y", rq[2*i].y, vb[i], 2);
            check("rt_inv_tag", rq[2*i].tag, 2 + (i % 2));
            check("rt_fwd_x", rq[2*i+1].x, dd[i]);
            check("rt_fwd_y", rq[2*i+1].y, dq[i]);
            check("rt_fwd_tag", rq[2*i+1].tag, i % 2);
        end

        // Reset with two samples in flight
        run1(1'b0, 2'b11, 131071, 131071, 32767, 32767);
        check("pre_rst_sticky", sat_sticky, 1);
        drive(1'b0, 2'b01, 16384, 0, 0, 32767);
        tick();
        tick();
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_x", out_x, 0);
        check("mid_rst_y", out_y, 0);
        check("mid_rst_tag", out_tag, 0);
        check("mid_rst_sat", out_sat, 0);
        check("mid_rst_sticky", sat_sticky, 0);
        tick();
        reset = 1'b1;
        check("post_rst_ready", in_ready, 1);
        tick(); tick(); tick();
        check("post_rst_flushed", out_valid, 0);
        send(1'b0, 2'b10, 16384, 0, 0, 32767);
        tick();
        check("post_rst_lat_early", out_valid, 0);
        tick();
        check("post_rst_lat_valid", out_valid, 1);
        check("post_rst_x", out_x, 16384);
        check("post_rst_tag", out_tag, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
